// File: rtl/haar_param_loader.sv
// Streams Haar cascade parameters from a ready/valid byte stream into the three
// per-stage banks, verifying a trailing modulo-2^DATA_WIDTH checksum before flagging them usable.
module haar_param_loader #(
  parameter int DATA_WIDTH                   = 8,
  parameter int NUM_STAGE_THRESHOLD          = 1,
  parameter int NUM_PARAM_PER_CLASSIFIER     = 18,
  parameter int NUM_CLASSIFIERS_FIRST_STAGE  = 10,
  parameter int NUM_CLASSIFIERS_SECOND_STAGE = 10,
  parameter int NUM_CLASSIFIERS_THIRD_STAGE  = 10,
  parameter int ADDR_WIDTH                   = 8
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  wr_en,
  output logic [1:0]            wr_stage,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  params_ready,
  output logic                  load_error,
  output logic                  busy
);

  localparam int W1 = NUM_CLASSIFIERS_FIRST_STAGE  * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam int W2 = NUM_CLASSIFIERS_SECOND_STAGE * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam int W3 = NUM_CLASSIFIERS_THIRD_STAGE  * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;

  localparam logic [ADDR_WIDTH-1:0] LAST1 = ADDR_WIDTH'(W1 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST2 = ADDR_WIDTH'(W2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST3 = ADDR_WIDTH'(W3 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   word_cnt;
  logic [DATA_WIDTH-1:0]   sum;
  logic                    accept;
  logic                    in_param;
  logic                    last_word;
  logic                    start_load;
  logic                    cksum_ok;

  logic                    vld_p1;
  logic [1:0]              stage_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]   data_p1;

  // Checksum arithmetic wraps naturally at the word width.
  function automatic logic [DATA_WIDTH-1:0] sum_mod(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic [1:0] stage_code(input state_t s);
    case (s)
      ST_S1:   return 2'd1;
      ST_S2:   return 2'd2;
      ST_S3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    data_ready = 1'b0;
    in_param   = 1'b0;
    last_word  = 1'b0;
    case (state)
      ST_S1:    begin data_ready = 1'b1; in_param = 1'b1; last_word = (word_cnt == LAST1); end
      ST_S2:    begin data_ready = 1'b1; in_param = 1'b1; last_word = (word_cnt == LAST2); end
      ST_S3:    begin data_ready = 1'b1; in_param = 1'b1; last_word = (word_cnt == LAST3); end
      ST_CHECK: data_ready = 1'b1;
      default:  ;
    endcase
  end

  assign busy     = data_ready;
  assign accept   = data_valid && data_ready;
  assign cksum_ok = (data_in == sum);

  always_comb begin
    state_next = state;
    start_load = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next = ST_S1;
          start_load = 1'b1;
        end
      end
      ST_S1:    if (accept && last_word) state_next = ST_S2;
      ST_S2:    if (accept && last_word) state_next = ST_S3;
      ST_S3:    if (accept && last_word) state_next = ST_CHECK;
      ST_CHECK: if (accept) state_next = cksum_ok ? ST_DONE : ST_ERR;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Stage p0: state, word index and running sum advance on each accepted word.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      sum      <= '0;
    end else begin
      state <= state_next;
      if (start_load) begin
        word_cnt <= '0;
        sum      <= '0;
      end else if (accept && in_param) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        sum      <= sum_mod(sum, data_in);
      end
    end
  end

  // Stage p1: registered bank write, one cycle after acceptance.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      vld_p1   <= 1'b0;
      stage_p1 <= '0;
      addr_p1  <= '0;
      data_p1  <= '0;
    end else begin
      vld_p1 <= accept && in_param;
      if (accept && in_param) begin
        stage_p1 <= stage_code(state);
        addr_p1  <= word_cnt;
        data_p1  <= data_in;
      end
    end
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      params_ready <= 1'b0;
      load_error   <= 1'b0;
    end else if (start_load) begin
      params_ready <= 1'b0;
      load_error   <= 1'b0;
    end else if (state == ST_CHECK && accept) begin
      params_ready <= cksum_ok;
      load_error   <= !cksum_ok;
    end
  end

  assign wr_en    = vld_p1;
  assign wr_stage = stage_p1;
  assign wr_addr  = addr_p1;
  assign wr_data  = data_p1;

endmodule

// File: tb/tb_haar_param_loader.sv
// Directed bench for haar_param_loader: full loads, bad checksum, stalls, ignored start, mid-load reset.
module tb_haar_param_loader;

  logic       clk_fpga   = 1'b0;
  logic       reset_fpga = 1'b0;
  logic       start      = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in    = 8'd0;
  logic       data_ready, wr_en, params_ready, load_error, busy;
  logic [1:0] wr_stage;
  logic [7:0] wr_addr, wr_data;

  int total = 0;
  int bad   = 0;

  logic [1:0] q_stage[$];
  logic [7:0] q_addr[$];
  logic [7:0] q_data[$];

  haar_param_loader dut (
    .clk_fpga     (clk_fpga),
    .reset_fpga   (reset_fpga),
    .start        (start),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .wr_en        (wr_en),
    .wr_stage     (wr_stage),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .params_ready (params_ready),
    .load_error   (load_error),
    .busy         (busy)
  );

  always #5 clk_fpga = ~clk_fpga;

  always @(negedge clk_fpga) begin
    if (wr_en === 1'b1) begin
      q_stage.push_back(wr_stage);
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic send_word(input logic [7:0] v);
    int n;
    n = 0;
    data_in    = v;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (data_ready !== 1'b1) check_val("ready_timeout", data_ready, 1);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_ready"}, data_ready, 0);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_wr_en"}, wr_en, 0);
    check_val({pfx, "_params_ready"}, params_ready, 0);
    check_val({pfx, "_load_error"}, load_error, 0);
    check_val({pfx, "_wr_stage"}, wr_stage, 0);
    check_val({pfx, "_wr_addr"}, wr_addr, 0);
    check_val({pfx, "_wr_data"}, wr_data, 0);
  endtask

  // Stream words i = 0..542 with value i mod 256, then the checksum word.
  task automatic run_load(input logic [7:0] cksum, input bit gaps, input int start_at);
    int g;
    q_stage.delete();
    q_addr.delete();
    q_data.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_clears_err", load_error, 0);
    check_val("start_clears_pr", params_ready, 0);
    check_val("ready_in_s1", data_ready, 1);
    for (int i = 0; i < 543; i++) begin
      if (gaps) begin
        g = (i == 180 || i == 181) ? 2 : int'($urandom_range(0, 2));
        repeat (g) tick();
      end
      if (i == start_at) start = 1'b1;
      send_word(i[7:0]);
      start = 1'b0;
      if (i == 0) begin
        check_val("first_wr_en", wr_en, 1);
        check_val("first_wr_stage", wr_stage, 1);
        check_val("first_wr_addr", wr_addr, 0);
      end
    end
    send_word(cksum);
  endtask

  task automatic check_writes();
    int errs;
    int es;
    int ea;
    errs = 0;
    check_val("wr_count", q_data.size(), 543);
    for (int j = 0; j < q_data.size() && j < 543; j++) begin
      es = (j < 181) ? 1 : (j < 362) ? 2 : 3;
      ea = j - 181 * (es - 1);
      if (q_stage[j] !== es[1:0] || q_addr[j] !== ea[7:0] || q_data[j] !== j[7:0]) errs++;
    end
    check_val("wr_seq_errs", errs, 0);
    if (q_data.size() == 543) begin
      check_val("wr180_stage", q_stage[180], 1);
      check_val("wr180_addr", q_addr[180], 180);
      check_val("wr180_data", q_data[180], 180);
      check_val("wr181_stage", q_stage[181], 2);
      check_val("wr181_addr", q_addr[181], 0);
      check_val("wr181_data", q_data[181], 181);
      check_val("wr542_stage", q_stage[542], 3);
      check_val("wr542_addr", q_addr[542], 180);
      check_val("wr542_data", q_data[542], 30);
    end
  endtask

  task automatic check_good_end(input string pfx);
    check_writes();
    check_val({pfx, "_params_ready"}, params_ready, 1);
    check_val({pfx, "_load_error"}, load_error, 0);
    check_val({pfx, "_ready_drop"}, data_ready, 0);
    check_val({pfx, "_busy_drop"}, busy, 0);
    check_val({pfx, "_no_cksum_wr"}, wr_en, 0);
  endtask

  initial begin
    // Reset and idle.
    #22;
    check_outputs_zero("in_reset");
    reset_fpga = 1'b1;
    repeat (10) tick();
    check_outputs_zero("idle");

    // Clean continuous load.
    run_load(8'd209, 1'b0, -1);
    check_good_end("load1");
    repeat (3) tick();
    check_val("pr_holds", params_ready, 1);

    // Bad checksum.
    run_load(8'd208, 1'b0, -1);
    check_writes();
    check_val("bad_load_error", load_error, 1);
    check_val("bad_params_ready", params_ready, 0);
    repeat (5) tick();
    check_val("err_holds", load_error, 1);
    check_val("err_idle_ready", data_ready, 0);

    // Random stalls including the stage-1/stage-2 boundary; its start clears the error.
    run_load(8'd209, 1'b1, -1);
    check_good_end("gaps");

    // Start pulsed mid stage 2 must be ignored.
    run_load(8'd209, 1'b0, 250);
    check_good_end("s2start");

    // Reset at word 300, then a fresh full load.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300; i++) send_word(i[7:0]);
    check_val("pre_abort_wr_en", wr_en, 1);
    #2;
    reset_fpga = 1'b0;
    #1;
    check_outputs_zero("abort");
    tick();
    #2;
    reset_fpga = 1'b1;
    repeat (3) tick();
    check_val("post_abort_ready", data_ready, 0);
    check_val("post_abort_pr", params_ready, 0);
    run_load(8'd209, 1'b0, -1);
    check_good_end("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/haar_param_loader.md
# haar_param_loader

Loads Haar classifier parameters for the three-stage face-detection cascade from an 8-bit ready/valid byte stream, from SDRAM/flash or the host bridge, and writes them word by word into the three per-stage parameter banks. The cascade reads those banks. The loader verifies a trailing modulo checksum and raises `params_ready` only after a complete, verified load; the cascade's candidate output is gated by `params_ready`.

## Interface
- `DATA_WIDTH`, 8, width of each parameter word and of the stream.
- `NUM_STAGE_THRESHOLD`, 1, threshold words appended after each stage's classifier words.
- `NUM_PARAM_PER_CLASSIFIER`, 18, words per classifier.
- `NUM_CLASSIFIERS_FIRST_STAGE`, 10, classifiers in stage 1.
- `NUM_CLASSIFIERS_SECOND_STAGE`, 10, classifiers in stage 2.
- `NUM_CLASSIFIERS_THIRD_STAGE`, 10, classifiers in stage 3.
- `ADDR_WIDTH`, 8, bank address width; must satisfy 2^ADDR_WIDTH ≥ largest stage word count.

Ports:
- `clk_fpga`, in, 1, single clock; all logic is rising-edge.
- `reset_fpga`, in, 1, asynchronous, active-low reset.
- `start`, in, 1, single-cycle load request.
- `data_in`, in, DATA_WIDTH, stream word.
- `data_valid`, in, 1, `data_in` is valid.
- `data_ready`, out, 1, loader accepts a word this cycle.
- `wr_en`, out, 1, bank write strobe.
- `wr_stage`, out, 2, target bank: 1, 2 or 3.
- `wr_addr`, out, ADDR_WIDTH, word index within the bank.
- `wr_data`, out, DATA_WIDTH, word to write.
- `params_ready`, out, 1, all banks loaded and checksum verified.
- `load_error`, out, 1, checksum mismatch on the last load.
- `busy`, out, 1, a load is in progress.

## Operation
- Stage n word count is `Wn = NUM_CLASSIFIERS_n*NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD`. With defaults, W1 = W2 = W3 = 181.
- Stream order: stage-1 words 0..W1-1, stage-2 words 0..W2-1, stage-3 words 0..W3-1, then one checksum word.
- A word is accepted on any cycle where `data_valid && data_ready`.
- States and transitions:
  - IDLE: `start` → S1.
  - S1: after accepting W1 words → S2.
  - S2: after accepting W2 words → S3.
  - S3: after accepting W3 words → CHECK.
  - CHECK: accepts one word. If it equals the running sum → DONE; otherwise → ERR.
  - DONE: `start` → S1.
  - ERR: `start` → S1.
- `data_ready` = 1 exactly in states S1, S2, S3 and CHECK. `busy` equals `data_ready`.
- Word index counter: cleared on `start` and at every stage transition; increments per accepted word.
- Running sum: sum of all accepted parameter words modulo 2^DATA_WIDTH. It is cleared on `start`. The checksum word is not added to it.
- `start` is ignored in S1, S2, S3 and CHECK. `start` in DONE or ERR clears `params_ready`, `load_error` and the sum in the same edge it enters S1.
- Stalls (`data_valid` = 0) may occur at any point, including inside stage boundaries. No state or counter changes while stalled.

## Timing
- Reset values: state IDLE; `data_ready`, `busy`, `wr_en`, `params_ready` and `load_error` are 0; `wr_stage`, `wr_addr`, `wr_data`, counters and sum are 0.
- Write latency: a word accepted at edge k produces `wr_en` = 1 together with its `wr_stage`, `wr_addr` and `wr_data` during cycle k+1 (registered). `wr_en` is high for exactly one cycle per accepted parameter word.
- The checksum word never produces `wr_en`.
- `params_ready` or `load_error` is set in the cycle after the checksum is accepted, and holds until the next `start` or reset.
- `data_ready` drops in the cycle after the checksum is accepted.
- Back-to-back streaming gives 1 word/cycle. A full default load takes 544 accepting cycles.
- Reset mid-load asynchronously returns everything to reset values. A partially written bank is not valid; `params_ready` stays 0.
- Stage boundary: the last word of S1 writes `wr_stage` = 1, `wr_addr` = W1-1. The next accepted word writes `wr_stage` = 2, `wr_addr` = 0, with no bubble required.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, `data_ready` 0.
- `start`, then stream 543 words with value (i mod 256), then checksum 0xD1 (209), continuous valid → 543 `wr_en` pulses; 544th stream word causes no write; `params_ready` = 1 next cycle, `load_error` = 0.
- Same stream with checksum 0xD0 → `load_error` = 1, `params_ready` = 0; a later `start` clears `load_error` upon entering S1.
- Random `data_valid` gaps, including across word 180/181 → write sequence includes (stage 1, addr 180, data 180) then (stage 2, addr 0, data 181 mod 256), with no duplicates and no drops.
- `start` pulsed during S2 → ignored; load completes unchanged with correct addresses.
- `reset_fpga` low at word 300 → outputs 0 immediately; a fresh `start` and full stream → `params_ready` = 1.
